// File: rtl/prng_range_sampler.sv
// Draws words from an LCG one strobe at a time and returns an unbiased integer in [0, N)
// using mask-and-reject sampling, with a bounded-retry fallback.
module prng_range_sampler #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned OUT_W     = 8,
    parameter int unsigned MAX_TRIES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OUT_W-1:0] range_n,
    output logic             prng_enable,
    input  logic [WIDTH-1:0] prng_rnd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_value,
    output logic             out_fallback
);

    localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        CHECK = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t           state;
    logic [OUT_W:0]   n_r;
    logic [OUT_W-1:0] mask_r;
    logic [TRY_W-1:0] tries;

    logic [OUT_W-1:0] cand_c;
    logic [OUT_W:0]   cand_ext_c;
    logic [OUT_W:0]   diff_c;
    logic [TRY_W-1:0] tries_inc_c;
    logic             accept_c;
    logic             last_try_c;
    logic             unused_bits;

    // All ones at and below the most significant set bit of v.
    function automatic logic [OUT_W-1:0] smear(input logic [OUT_W-1:0] v);
        logic [OUT_W-1:0] m;
        logic             acc;
        m   = '0;
        acc = 1'b0;
        for (int i = int'(OUT_W) - 1; i >= 0; i--) begin
            acc  = acc | v[i];
            m[i] = acc;
        end
        return m;
    endfunction

    // N is held in OUT_W+1 bits so N=0 becomes 2^OUT_W and every candidate passes.
    assign cand_c      = prng_rnd[WIDTH-1 -: OUT_W] & mask_r;
    assign cand_ext_c  = {1'b0, cand_c};
    assign accept_c    = cand_ext_c < n_r;
    assign diff_c      = cand_ext_c - n_r;
    assign tries_inc_c = tries + TRY_W'(1);
    assign last_try_c  = (tries_inc_c == TRY_W'(MAX_TRIES));
    assign unused_bits = ^{prng_rnd, diff_c};

    assign req_ready   = (state == IDLE);
    assign prng_enable = (state == DRAW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            n_r          <= '0;
            mask_r       <= '0;
            tries        <= '0;
            out_valid    <= 1'b0;
            out_value    <= '0;
            out_fallback <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        n_r    <= {(range_n == '0), range_n};
                        mask_r <= smear(range_n - OUT_W'(1));
                        tries  <= '0;
                        state  <= DRAW;
                    end
                end
                DRAW: state <= CHECK;
                CHECK: begin
                    if (accept_c) begin
                        out_value    <= cand_c;
                        out_fallback <= 1'b0;
                        out_valid    <= 1'b1;
                        state        <= OUT;
                    end else begin
                        tries <= tries_inc_c;
                        // Masked candidate is < 2N, so cand-N always lands in range.
                        if (last_try_c) begin
                            out_value    <= diff_c[OUT_W-1:0];
                            out_fallback <= 1'b1;
                            out_valid    <= 1'b1;
                            state        <= OUT;
                        end else begin
                            state <= DRAW;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prng_range_sampler.sv
// Scoreboard bench for prng_range_sampler: a behavioural LCG / stub word source feeds the DUT,
// a monitor checks each handshake result, latency and strobe count against queued expectations.
module tb_prng_range_sampler;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned OUT_W     = 8;
    localparam int unsigned MAX_TRIES = 16;

    typedef struct {
        logic [OUT_W-1:0] value;
        logic             fallback;
        int               latency;
        int               pulses;
        string            name;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [OUT_W-1:0] range_n;
    logic             prng_enable;
    logic [WIDTH-1:0] prng_rnd;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_value;
    logic             out_fallback;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int enable_total = 0;
    bit use_lcg;

    exp_t             sb_q[$];
    logic [WIDTH-1:0] stub_q[$];

    prng_range_sampler #(
        .WIDTH    (WIDTH),
        .OUT_W    (OUT_W),
        .MAX_TRIES(MAX_TRIES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .range_n     (range_n),
        .prng_enable (prng_enable),
        .prng_rnd    (prng_rnd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_value   (out_value),
        .out_fallback(out_fallback)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Word source: glibc-style LCG or a queue of stub words; holds its value when not stepped.
    always @(posedge clk) begin
        if (prng_enable) begin
            enable_total <= enable_total + 1;
            if (use_lcg)
                prng_rnd <= prng_rnd * 32'd1103515245 + 32'd12345;
            else if (stub_q.size() > 0)
                prng_rnd <= stub_q.pop_front();
        end
    end

    task automatic check(input bit ok, input string name, input int act, input int exp_v);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp_v, exp_v);
        end
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard at each output handshake.
    int               accept_cyc = 0;
    int               first_valid_cyc = 0;
    int               pulses = 0;
    bit               seen_valid = 1'b0;
    logic [OUT_W-1:0] held_value;
    logic             held_fb;

    always @(negedge clk) begin
        if (rst) begin
            seen_valid = 1'b0;
            pulses     = 0;
        end else begin
            if (req_valid && req_ready) begin
                accept_cyc = cyc;
                pulses     = 0;
                seen_valid = 1'b0;
            end
            if (prng_enable) pulses++;
            if (out_valid) begin
                if (!seen_valid) begin
                    seen_valid      = 1'b1;
                    first_valid_cyc = cyc;
                    held_value      = out_value;
                    held_fb         = out_fallback;
                end else begin
                    check(out_value == held_value, "hold_value", int'(out_value), int'(held_value));
                    check(out_fallback == held_fb, "hold_fallback", int'(out_fallback), int'(held_fb));
                end
                check(req_ready == 1'b0, "out_req_ready_low", int'(req_ready), 0);
                check(prng_enable == 1'b0, "out_no_enable", int'(prng_enable), 0);
                if (out_ready) begin
                    if (sb_q.size() == 0) begin
                        check(1'b0, "unexpected_output", int'(out_value), -1);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check(out_value == e.value, {e.name, "_value"}, int'(out_value), int'(e.value));
                        check(out_fallback == e.fallback, {e.name, "_fallback"},
                              int'(out_fallback), int'(e.fallback));
                        check(first_valid_cyc - accept_cyc == e.latency, {e.name, "_latency"},
                              first_valid_cyc - accept_cyc, e.latency);
                        check(pulses == e.pulses, {e.name, "_pulses"}, pulses, e.pulses);
                    end
                    seen_valid = 1'b0;
                end
            end
        end
    end

    task automatic expect_result(input string name, input int value, input bit fb,
                                 input int lat, input int pls);
        exp_t e;
        e.value    = OUT_W'(value);
        e.fallback = fb;
        e.latency  = lat;
        e.pulses   = pls;
        e.name     = name;
        sb_q.push_back(e);
    endtask

    task automatic wait_done(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && req_ready && !out_valid) done = 1'b1;
        end
        if (!done) check(1'b0, {name, "_timeout"}, sb_q.size(), 0);
    endtask

    task automatic send_req(input int n);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        range_n   = OUT_W'(n);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        int  acc;
        int  c0;
        int  en_before;
        bit  got;

        rst       = 1'b1;
        req_valid = 1'b0;
        range_n   = '0;
        out_ready = 1'b1;
        use_lcg   = 1'b1;
        prng_rnd  = 32'd1;

        #2;
        check(req_ready == 1'b1, "rst_req_ready", int'(req_ready), 1);
        check(out_valid == 1'b0, "rst_out_valid", int'(out_valid), 0);
        check(prng_enable == 1'b0, "rst_prng_enable", int'(prng_enable), 0);
        check(out_value == '0, "rst_out_value", int'(out_value), 0);
        check(out_fallback == 1'b0, "rst_out_fallback", int'(out_fallback), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Real LCG, seed 1: first word 0x41C67EA6 -> 0x41 & 0x7F = 65 < 100.
        expect_result("lcg_first", 65, 1'b0, 3, 1);
        send_req(100);
        wait_done("lcg_first");

        use_lcg = 1'b0;

        // 0xFF -> 127 rejected, then 0x10 -> 16.
        stub_q.push_back(32'hFF00_0000);
        stub_q.push_back(32'h1000_0000);
        expect_result("reject_once", 16, 1'b0, 5, 2);
        send_req(100);
        wait_done("reject_once");

        // Constant 0xFF exhausts the tries: 127 - 100 = 27 via fallback.
        stub_q.push_back(32'hFF12_3456);
        expect_result("fallback", 27, 1'b1, 1 + 2 * int'(MAX_TRIES), int'(MAX_TRIES));
        send_req(100);
        wait_done("fallback");

        stub_q.push_back(32'hAB00_0000);
        expect_result("n_one", 0, 1'b0, 3, 1);
        send_req(1);
        wait_done("n_one");

        stub_q.push_back(32'hC300_0000);
        expect_result("n_zero", 'hC3, 1'b0, 3, 1);
        send_req(0);
        wait_done("n_zero");

        // Downstream stall for 10 cycles; the monitor checks hold, ready and strobe each cycle.
        stub_q.push_back(32'h2000_0000);
        expect_result("stall", 32, 1'b0, 3, 1);
        out_ready = 1'b0;
        send_req(100);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
        end
        check(got, "stall_valid_seen", int'(got), 1);
        repeat (10) @(negedge clk);
        check(sb_q.size() == 1, "stall_not_consumed", sb_q.size(), 1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done("stall");

        // Back-to-back requests: accepts spaced exactly 4 cycles apart.
        stub_q.push_back(32'h0500_0000);
        stub_q.push_back(32'h0600_0000);
        expect_result("b2b_a", 5, 1'b0, 3, 1);
        expect_result("b2b_b", 6, 1'b0, 3, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        range_n   = OUT_W'(200);
        acc = 0;
        c0  = 0;
        for (int i = 0; i < 50 && acc < 2; i++) begin
            @(negedge clk);
            if (req_ready) begin
                if (acc == 0) c0 = cyc;
                else check(cyc - c0 == 4, "b2b_interval", cyc - c0, 4);
                acc++;
            end
        end
        check(acc == 2, "b2b_accepts", acc, 2);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_done("b2b");

        // Reset asserted while the strobe is high.
        stub_q.push_back(32'h0100_0000);
        send_req(100);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (prng_enable) got = 1'b1;
        end
        check(got, "rst_draw_seen", int'(got), 1);
        #1 rst = 1'b1;
        #1;
        check(prng_enable == 1'b0, "midrst_prng_enable", int'(prng_enable), 0);
        check(req_ready == 1'b1, "midrst_req_ready", int'(req_ready), 1);
        check(out_valid == 1'b0, "midrst_out_valid", int'(out_valid), 0);
        check(out_value == '0, "midrst_out_value", int'(out_value), 0);
        check(out_fallback == 1'b0, "midrst_out_fallback", int'(out_fallback), 0);
        en_before = enable_total;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check(req_ready == 1'b1, "postrst_req_ready", int'(req_ready), 1);
        repeat (10) @(negedge clk);
        check(enable_total == en_before, "postrst_no_strobe", enable_total, en_before);
        check(out_valid == 1'b0, "postrst_out_valid", int'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
